truss_watchdog_sequencer: RTL and testbench

- Hardware test-completion and watchdog controller for the truss testbench.
- Collects heartbeat and done status from N verification components and detects the end of the test or a hang.
- Then runs a shutdown handshake with every component and reports pass/fail to the test-level shutdown logic.
- Sits beside the DUT harness. Only the testbench drives it; it has no DUT-facing ports.

---
 rtl/truss_watchdog_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_truss_watchdog_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truss_watchdog_sequencer.sv
// Test-completion and watchdog sequencer: RUN -> DRAIN -> SHUTDOWN handshake -> FINISHED with pass/fail.
// Optional macro TRUSS_WATCHDOG_CULPRIT_EN adds the culprit capture output.

module truss_watchdog_sequencer_param_chk #(
   parameter int N_COMP       = 4,
   parameter int TIMEOUT      = 1000,
   parameter int DRAIN_CYCLES = 16,
   parameter int ACK_TIMEOUT  = 64,
   parameter int CNT_W        = 32
);
   localparam logic [64:0] max_val_c = (65'd1 << CNT_W) - 65'd1;

   if (CNT_W < 2 || CNT_W > 64) begin : g_bad_cnt_w
      $error("CNT_W must be in 2..64");
   end
   if (N_COMP < 1 || N_COMP > 16) begin : g_bad_n_comp
      $error("N_COMP must be in 1..16");
   end
   if (TIMEOUT < 2 || 65'(TIMEOUT) > max_val_c) begin : g_bad_timeout
      $error("TIMEOUT must be >= 2 and fit in CNT_W bits");
   end
   if (DRAIN_CYCLES < 1 || 65'(DRAIN_CYCLES) > max_val_c) begin : g_bad_drain
      $error("DRAIN_CYCLES must be >= 1 and fit in CNT_W bits");
   end
   if (ACK_TIMEOUT < 1 || 65'(ACK_TIMEOUT) > max_val_c) begin : g_bad_ack
      $error("ACK_TIMEOUT must be >= 1 and fit in CNT_W bits");
   end
endmodule

module truss_watchdog_sequencer #(
   parameter int N_COMP       = 4,
   parameter int TIMEOUT      = 1000,
   parameter int DRAIN_CYCLES = 16,
   parameter int ACK_TIMEOUT  = 64,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_COMP-1:0] heartbeat,
   input  logic [N_COMP-1:0] done,
   input  logic [N_COMP-1:0] shut_ack,
   output logic              shutdown_req,
   output logic              finished,
   output logic              pass,
   output logic              timed_out,
   output logic [2:0]        state,
   output logic [CNT_W-1:0]  idle_cnt
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
   ,
   output logic [N_COMP-1:0] culprit
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_SHUTDOWN = 3'd3,
      ST_FINISHED = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] cnt_zero_c     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] cnt_one_c      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] timeout_last_c = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] drain_last_c   = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] ack_last_c     = CNT_W'(ACK_TIMEOUT - 1);

   truss_watchdog_sequencer_param_chk #(
      .N_COMP      (N_COMP),
      .TIMEOUT     (TIMEOUT),
      .DRAIN_CYCLES(DRAIN_CYCLES),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_param_chk ();

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + cnt_one_c;
      end
   endfunction

   state_t           state_r, state_s;
   logic [CNT_W-1:0] idle_cnt_r, idle_cnt_s;
   logic [CNT_W-1:0] drain_cnt_r, drain_cnt_s;
   logic [CNT_W-1:0] ack_cnt_r, ack_cnt_s;
   logic             shutdown_req_r, shutdown_req_s;
   logic             finished_r, finished_s;
   logic             pass_r, pass_s;
   logic             timed_out_r, timed_out_s;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
   logic [N_COMP-1:0] culprit_r, culprit_s;
`endif

   logic             hb_any_s, all_done_s, all_ack_s, wd_expire_s;
   logic [CNT_W-1:0] idle_step_s;

   assign hb_any_s    = |heartbeat;
   assign all_done_s  = &done;
   assign all_ack_s   = &shut_ack;
   // The watchdog fires on the last idle count only if no heartbeat rescues it this cycle.
   assign wd_expire_s = (idle_cnt_r == timeout_last_c) && !hb_any_s;
   assign idle_step_s = hb_any_s ? cnt_zero_c : sat_inc(idle_cnt_r);

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_s        = state_r;
      idle_cnt_s     = idle_cnt_r;
      drain_cnt_s    = drain_cnt_r;
      ack_cnt_s      = ack_cnt_r;
      shutdown_req_s = shutdown_req_r;
      finished_s     = finished_r;
      pass_s         = pass_r;
      timed_out_s    = timed_out_r;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
      culprit_s      = culprit_r;
`endif
      case (state_r)
         ST_IDLE: begin
            idle_cnt_s  = cnt_zero_c;
            drain_cnt_s = cnt_zero_c;
            ack_cnt_s   = cnt_zero_c;
            if (start) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN, ST_DRAIN: begin
            idle_cnt_s = idle_step_s;
            if (wd_expire_s) begin
               state_s        = ST_SHUTDOWN;
               shutdown_req_s = 1'b1;
               timed_out_s    = 1'b1;
               drain_cnt_s    = cnt_zero_c;
               ack_cnt_s      = cnt_zero_c;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
               culprit_s      = ~done;
`endif
            end else if (!all_done_s) begin
               state_s     = ST_RUN;
               drain_cnt_s = cnt_zero_c;
            end else if (state_r == ST_RUN) begin
               state_s     = ST_DRAIN;
               drain_cnt_s = cnt_zero_c;
            end else if (drain_cnt_r == drain_last_c) begin
               state_s        = ST_SHUTDOWN;
               shutdown_req_s = 1'b1;
               drain_cnt_s    = cnt_zero_c;
               ack_cnt_s      = cnt_zero_c;
            end else begin
               drain_cnt_s = drain_cnt_r + cnt_one_c;
            end
         end
         ST_SHUTDOWN: begin
            idle_cnt_s = idle_step_s;
            // Acks are checked first so a last-moment full ack beats the ack timeout.
            if (all_ack_s) begin
               state_s        = ST_FINISHED;
               shutdown_req_s = 1'b0;
               finished_s     = 1'b1;
               pass_s         = !timed_out_r;
            end else if (ack_cnt_r == ack_last_c) begin
               state_s        = ST_FINISHED;
               shutdown_req_s = 1'b0;
               finished_s     = 1'b1;
               pass_s         = 1'b0;
               timed_out_s    = 1'b1;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
               culprit_s      = ~shut_ack;
`endif
            end else begin
               ack_cnt_s = ack_cnt_r + cnt_one_c;
            end
         end
         ST_FINISHED: begin
            state_s = ST_FINISHED;
         end
         default: begin
            state_s        = ST_IDLE;
            idle_cnt_s     = cnt_zero_c;
            drain_cnt_s    = cnt_zero_c;
            ack_cnt_s      = cnt_zero_c;
            shutdown_req_s = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         idle_cnt_r     <= cnt_zero_c;
         drain_cnt_r    <= cnt_zero_c;
         ack_cnt_r      <= cnt_zero_c;
         shutdown_req_r <= 1'b0;
         finished_r     <= 1'b0;
         pass_r         <= 1'b0;
         timed_out_r    <= 1'b0;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
         culprit_r      <= {N_COMP{1'b0}};
`endif
      end else begin
         state_r        <= state_s;
         idle_cnt_r     <= idle_cnt_s;
         drain_cnt_r    <= drain_cnt_s;
         ack_cnt_r      <= ack_cnt_s;
         shutdown_req_r <= shutdown_req_s;
         finished_r     <= finished_s;
         pass_r         <= pass_s;
         timed_out_r    <= timed_out_s;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
         culprit_r      <= culprit_s;
`endif
      end
   end

   assign state        = state_r;
   assign idle_cnt     = idle_cnt_r;
   assign shutdown_req = shutdown_req_r;
   assign finished     = finished_r;
   assign pass         = pass_r;
   assign timed_out    = timed_out_r;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
   assign culprit      = culprit_r;
`endif

endmodule

// File: tb/tb_truss_watchdog_sequencer.sv
// Self-checking bench for truss_watchdog_sequencer: directed scenarios plus randomized runs
// compared against a cycle-level behavioural model of the sequencing rules.

module tb_truss_watchdog_sequencer;
   localparam int N  = 4;
   localparam int TO = 1000;
   localparam int DR = 16;
   localparam int AK = 64;
   localparam int CW = 32;

   logic          clk;
   logic          reset, start;
   logic [N-1:0]  heartbeat, done, shut_ack;
   logic          shutdown_req, finished, pass, timed_out;
   logic [2:0]    state;
   logic [CW-1:0] idle_cnt;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
   logic [N-1:0]  culprit;
   logic [N-1:0]  m_culprit;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: phase number, cycles since last heartbeat, cycles spent in DRAIN / SHUTDOWN.
   int m_state, m_idle, m_drain_el, m_sd_el;
   bit m_sreq, m_fin, m_pass, m_to;

   truss_watchdog_sequencer #(
      .N_COMP(N), .TIMEOUT(TO), .DRAIN_CYCLES(DR), .ACK_TIMEOUT(AK), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .heartbeat(heartbeat), .done(done),
      .shut_ack(shut_ack), .shutdown_req(shutdown_req), .finished(finished), .pass(pass),
      .timed_out(timed_out), .state(state), .idle_cnt(idle_cnt)
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
      , .culprit(culprit)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic enter_shutdown();
      m_state = 3; m_sreq = 1'b1; m_sd_el = 0;
   endtask

   task automatic model_step();
      bit hb, alldone, allack, expire;
      if (reset) begin
         m_state = 0; m_idle = 0; m_drain_el = 0; m_sd_el = 0;
         m_sreq = 1'b0; m_fin = 1'b0; m_pass = 1'b0; m_to = 1'b0;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
         m_culprit = '0;
`endif
         return;
      end
      hb      = (heartbeat != 4'h0);
      alldone = (done == 4'hF);
      allack  = (shut_ack == 4'hF);
      case (m_state)
         0: if (start) m_state = 1;
         1, 2: begin
            expire = !hb && (m_idle == TO - 1);
            m_idle = hb ? 0 : m_idle + 1;
            if (expire) begin
               m_to = 1'b1;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
               m_culprit = ~done;
`endif
               enter_shutdown();
            end else if (!alldone) begin
               m_state = 1; m_drain_el = 0;
            end else if (m_state == 1) begin
               m_state = 2; m_drain_el = 0;
            end else begin
               m_drain_el++;
               if (m_drain_el == DR) enter_shutdown();
            end
         end
         3: begin
            m_idle = hb ? 0 : m_idle + 1;
            m_sd_el++;
            if (allack) begin
               m_state = 4; m_sreq = 1'b0; m_fin = 1'b1; m_pass = !m_to;
            end else if (m_sd_el == AK) begin
               m_state = 4; m_sreq = 1'b0; m_fin = 1'b1; m_pass = 1'b0; m_to = 1'b1;
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
               m_culprit = ~shut_ack;
`endif
            end
         end
         default: ;
      endcase
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [3:0] rand_partial();
      logic [3:0] v;
      v = 4'($urandom);
      v[2'($urandom_range(0, 3))] = 1'b0;
      return v;
   endfunction

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; heartbeat = '0; done = '0; shut_ack = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; heartbeat = 4'($urandom); done = 4'hF; shut_ack = 4'hF;
      tick();
      tick();
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
      n_vec++; if (shutdown_req !== 1'b0) begin n_err++; $display("FAIL reset_sreq: got %b want 0", shutdown_req); end
      n_vec++; if (finished !== 1'b0) begin n_err++; $display("FAIL reset_finished: got %b want 0", finished); end
      n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b want 0", pass); end
      n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL reset_timed_out: got %b want 0", timed_out); end
      n_vec++; if (idle_cnt !== 32'd0) begin n_err++; $display("FAIL reset_idle_cnt: got %0d want 0", idle_cnt); end
      reset = 1'b0; start = 1'b0;
   endtask

   task automatic test_clean_run();
      int sreq_cyc = -1, fin_cyc = -1;
      do_reset();
      for (int cyc = 0; cyc < 300; cyc++) begin
         start     = (cyc == 0);
         heartbeat = (cyc % 10 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         done      = (cyc >= 200) ? 4'hF : rand_partial();
         shut_ack  = (sreq_cyc >= 0 && cyc >= sreq_cyc + 5) ? 4'hF : 4'h0;
         tick();
         n_vec++;
         if ({state, shutdown_req, finished, pass, timed_out, idle_cnt} !==
             {3'(m_state), m_sreq, m_fin, m_pass, m_to, 32'(m_idle)}) begin
            n_err++;
            $display("FAIL clean_cycle%0d: got st=%0d sreq=%b fin=%b pass=%b to=%b idle=%0d want st=%0d sreq=%b fin=%b pass=%b to=%b idle=%0d",
                     cyc + 1, state, shutdown_req, finished, pass, timed_out, idle_cnt,
                     m_state, m_sreq, m_fin, m_pass, m_to, m_idle);
         end
         if (shutdown_req === 1'b1 && sreq_cyc < 0) sreq_cyc = cyc + 1;
         if (finished === 1'b1 && fin_cyc < 0) fin_cyc = cyc + 1;
         if (fin_cyc >= 0 && cyc + 1 >= fin_cyc + 2) break;
      end
      n_vec++; if (sreq_cyc != 200 + DR + 1) begin n_err++; $display("FAIL clean_sreq_cycle: got %0d want %0d", sreq_cyc, 200 + DR + 1); end
      n_vec++; if (fin_cyc != 200 + DR + 1 + 6) begin n_err++; $display("FAIL clean_fin_cycle: got %0d want %0d", fin_cyc, 200 + DR + 7); end
      n_vec++; if ({finished, pass, timed_out} !== 3'b110) begin n_err++; $display("FAIL clean_flags: got fin/pass/to=%b want 110", {finished, pass, timed_out}); end
   endtask

   task automatic test_watchdog();
      int sreq_cyc = -1, fin_cyc = -1;
      do_reset();
      for (int cyc = 0; cyc < TO + 50; cyc++) begin
         start     = (cyc == 0);
         heartbeat = (cyc == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
         done      = 4'h0;
         shut_ack  = (sreq_cyc >= 0 && cyc >= sreq_cyc + 3) ? 4'hF : 4'h0;
         tick();
         if (cyc + 1 == 3 + TO) begin
            n_vec++; if (idle_cnt !== 32'(TO - 1)) begin n_err++; $display("FAIL wd_idle_before: got %0d want %0d", idle_cnt, TO - 1); end
         end
         if (shutdown_req === 1'b1 && sreq_cyc < 0) sreq_cyc = cyc + 1;
         if (finished === 1'b1 && fin_cyc < 0) fin_cyc = cyc + 1;
         if (fin_cyc >= 0) break;
      end
      // Idle counts 0..TO-1 over cycles 4..TO+3; SHUTDOWN appears on the following cycle.
      n_vec++; if (sreq_cyc != 3 + TO + 1) begin n_err++; $display("FAIL wd_sreq_cycle: got %0d want %0d", sreq_cyc, 3 + TO + 1); end
      n_vec++; if (fin_cyc != 3 + TO + 1 + 4) begin n_err++; $display("FAIL wd_fin_cycle: got %0d want %0d", fin_cyc, 3 + TO + 5); end
      n_vec++; if ({finished, pass, timed_out} !== 3'b101) begin n_err++; $display("FAIL wd_flags: got fin/pass/to=%b want 101", {finished, pass, timed_out}); end
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
      n_vec++; if (culprit !== 4'b1111) begin n_err++; $display("FAIL wd_culprit: got %b want 1111", culprit); end
`endif
   endtask

   task automatic test_done_drop();
      int obs[0:99];
      do_reset();
      for (int cyc = 0; cyc < 90; cyc++) begin
         start     = (cyc == 0);
         heartbeat = (cyc % 4 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         if (cyc < 50)      done = rand_partial();
         else if (cyc < 55) done = 4'hF;
         else if (cyc < 60) done = 4'b1011;
         else               done = 4'hF;
         shut_ack = 4'hF;
         tick();
         obs[cyc + 1] = int'(state);
         n_vec++;
         if ({state, shutdown_req, finished, pass, timed_out, idle_cnt} !==
             {3'(m_state), m_sreq, m_fin, m_pass, m_to, 32'(m_idle)}) begin
            n_err++;
            $display("FAIL drop_cycle%0d: got st=%0d sreq=%b fin=%b idle=%0d want st=%0d sreq=%b fin=%b idle=%0d",
                     cyc + 1, state, shutdown_req, finished, idle_cnt, m_state, m_sreq, m_fin, m_idle);
         end
      end
      n_vec++; if (obs[51] != 2) begin n_err++; $display("FAIL drop_drain51: got %0d want 2", obs[51]); end
      n_vec++; if (obs[56] != 1) begin n_err++; $display("FAIL drop_run56: got %0d want 1", obs[56]); end
      n_vec++; if (obs[61] != 2) begin n_err++; $display("FAIL drop_drain61: got %0d want 2", obs[61]); end
      n_vec++; if (obs[76] != 2) begin n_err++; $display("FAIL drop_drain76: got %0d want 2", obs[76]); end
      n_vec++; if (obs[77] != 3) begin n_err++; $display("FAIL drop_shutdown77: got %0d want 3", obs[77]); end
      n_vec++; if (obs[78] != 4) begin n_err++; $display("FAIL drop_finished78: got %0d want 4", obs[78]); end
   endtask

   // Runs done-at-cycle-5 into SHUTDOWN; last_ack selects a full ack on the final allowed cycle.
   task automatic run_ack_case(input bit last_ack, output int fin_cyc, output int st_before);
      int sreq_exp;
      sreq_exp = 5 + DR + 1;
      fin_cyc = -1; st_before = -1;
      do_reset();
      for (int cyc = 0; cyc < sreq_exp + AK + 10; cyc++) begin
         start     = (cyc == 0);
         heartbeat = (cyc % 4 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         done      = (cyc >= 5) ? 4'hF : rand_partial();
         shut_ack  = (last_ack && cyc == sreq_exp + AK - 1) ? 4'hF : (last_ack ? 4'b0111 : 4'b1101);
         tick();
         if (cyc + 1 == sreq_exp + AK - 1) st_before = int'(state);
         if (finished === 1'b1 && fin_cyc < 0) fin_cyc = cyc + 1;
         if (fin_cyc >= 0) break;
      end
   endtask

   task automatic test_ack_timeout();
      int fin_cyc, st_before;
      run_ack_case(1'b0, fin_cyc, st_before);
      n_vec++; if (st_before != 3) begin n_err++; $display("FAIL ackto_still_shutdown: got %0d want 3", st_before); end
      n_vec++; if (fin_cyc != 5 + DR + 1 + AK) begin n_err++; $display("FAIL ackto_fin_cycle: got %0d want %0d", fin_cyc, 5 + DR + 1 + AK); end
      n_vec++; if ({finished, pass, timed_out, shutdown_req} !== 4'b1010) begin n_err++; $display("FAIL ackto_flags: got fin/pass/to/sreq=%b want 1010", {finished, pass, timed_out, shutdown_req}); end
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
      n_vec++; if (culprit !== 4'b0010) begin n_err++; $display("FAIL ackto_culprit: got %b want 0010", culprit); end
`endif
   endtask

   task automatic test_ack_last_cycle();
      int fin_cyc, st_before;
      run_ack_case(1'b1, fin_cyc, st_before);
      n_vec++; if (fin_cyc != 5 + DR + 1 + AK) begin n_err++; $display("FAIL acklast_fin_cycle: got %0d want %0d", fin_cyc, 5 + DR + 1 + AK); end
      n_vec++; if ({finished, pass, timed_out} !== 3'b110) begin n_err++; $display("FAIL acklast_flags: got fin/pass/to=%b want 110", {finished, pass, timed_out}); end
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
      n_vec++; if (culprit !== 4'b0000) begin n_err++; $display("FAIL acklast_culprit: got %b want 0000", culprit); end
`endif
   endtask

   task automatic test_timeout_done_conflict();
      do_reset();
      for (int cyc = 0; cyc <= TO; cyc++) begin
         start     = (cyc == 0);
         heartbeat = 4'h0;
         done      = (cyc == TO) ? 4'hF : 4'h0;
         shut_ack  = 4'h0;
         tick();
      end
      n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL conflict_state: got %0d want 3", state); end
      n_vec++; if ({shutdown_req, timed_out} !== 2'b11) begin n_err++; $display("FAIL conflict_flags: got sreq/to=%b want 11", {shutdown_req, timed_out}); end
   endtask

   task automatic test_reset_mid_shutdown();
      n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL rstmid_pre_state: got %0d want 3", state); end
      reset = 1'b1; start = 1'b1; heartbeat = 4'hF; done = 4'hF; shut_ack = 4'h0;
      tick();
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL rstmid_state: got %0d want 0", state); end
      n_vec++; if ({shutdown_req, finished, timed_out} !== 3'b000) begin n_err++; $display("FAIL rstmid_flags: got sreq/fin/to=%b want 000", {shutdown_req, finished, timed_out}); end
      n_vec++; if (idle_cnt !== 32'd0) begin n_err++; $display("FAIL rstmid_idle: got %0d want 0", idle_cnt); end
      reset = 1'b0; start = 1'b0;
      tick();
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL rstmid_start_ignored: got %0d want 0", state); end
   endtask

   task automatic test_random();
      for (int run = 0; run < 6; run++) begin
         do_reset();
         for (int cyc = 0; cyc < 300; cyc++) begin
            start     = (cyc == 0) || ($urandom_range(0, 19) == 0);
            heartbeat = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 9) == 0)  done[2'($urandom_range(0, 3))] = 1'b1;
            if ($urandom_range(0, 39) == 0) done[2'($urandom_range(0, 3))] = 1'b0;
            shut_ack  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
            tick();
            n_vec++;
            if ({state, shutdown_req, finished, pass, timed_out, idle_cnt} !==
                {3'(m_state), m_sreq, m_fin, m_pass, m_to, 32'(m_idle)}) begin
               n_err++;
               $display("FAIL rand%0d_cycle%0d: got st=%0d sreq=%b fin=%b pass=%b to=%b idle=%0d want st=%0d sreq=%b fin=%b pass=%b to=%b idle=%0d",
                        run, cyc + 1, state, shutdown_req, finished, pass, timed_out, idle_cnt,
                        m_state, m_sreq, m_fin, m_pass, m_to, m_idle);
            end
`ifdef TRUSS_WATCHDOG_CULPRIT_EN
            n_vec++;
            if (culprit !== m_culprit) begin
               n_err++; $display("FAIL rand%0d_culprit%0d: got %b want %b", run, cyc + 1, culprit, m_culprit);
            end
`endif
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; heartbeat = '0; done = '0; shut_ack = '0;
      test_reset();
      test_clean_run();
      test_watchdog();
      test_done_drop();
      test_ack_timeout();
      test_ack_last_cycle();
      test_timeout_done_conflict();
      test_reset_mid_shutdown();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
